// File: rtl/io_input_ctrl_pkg.sv
// Shared types and constants for the I/O input-port controller.
// Register offsets are word indices on addr[7:2].
package io_input_ctrl_pkg;

    localparam int PORT_W              = 4;
    localparam int NUM_PORTS           = 2;
    localparam int DEBOUNCE_CYCLES_DEF = 4;
    localparam int CNT_W_DEF           = 3;

    typedef enum logic [5:0] {
        IO_IN0  = 6'h20,
        IO_IN1  = 6'h21,
        IO_STAT = 6'h22,
        IO_MASK = 6'h23
    } io_reg_e;

    function automatic logic [31:0] zext_port(input logic [PORT_W-1:0] v);
        return {{(32-PORT_W){1'b0}}, v};
    endfunction

    function automatic logic [31:0] zext_flags(input logic [NUM_PORTS-1:0] v);
        return {{(32-NUM_PORTS){1'b0}}, v};
    endfunction

endpackage

// File: rtl/io_debounce.sv
// Two-flop synchroniser plus debouncer for one 4-bit input port.
// Latency: pin stable before edge 1 is accepted at edge DEBOUNCE_CYCLES+3; no backpressure.
module io_debounce
    import io_input_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic              io_clk,
    input  logic              reset,
    input  logic [PORT_W-1:0] pin_i,
    output logic [PORT_W-1:0] stable_o,
    output logic              chg_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [PORT_W-1:0] s1_q, s2_q;
    logic [PORT_W-1:0] cand_q, cand_d;
    logic [PORT_W-1:0] stable_q, stable_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Any movement at s2 restarts the count; only an unchanged candidate that
    // differs from the accepted value advances toward acceptance.
    always_comb begin
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        chg_o    = 1'b0;
        if (s2_q != cand_q) begin
            cand_d = s2_q;
            cnt_d  = '0;
        end else if (cand_q != stable_q) begin
            if (cnt_q == CNT_MAX) begin
                stable_d = cand_q;
                cnt_d    = '0;
                chg_o    = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge io_clk or posedge reset) begin
        if (reset) begin
            s1_q     <= '0;
            s2_q     <= '0;
            cand_q   <= '0;
            cnt_q    <= '0;
            stable_q <= '0;
        end else begin
            s1_q     <= pin_i;
            s2_q     <= s1_q;
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign stable_o = stable_q;

endmodule

// File: rtl/io_input_ctrl.sv
// Memory-mapped input-port block: debounced ports, change flags, irq mask, read mux.
// Latency: read data combinational, flag/mask updates next edge; no backpressure.
module io_input_ctrl
    import io_input_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic        io_clk,
    input  logic        reset,
    input  logic [3:0]  in_port0,
    input  logic [3:0]  in_port1,
    input  logic [31:0] addr,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] wr_data,
    output logic [31:0] io_read_data,
    output logic        irq
);

    logic [PORT_W-1:0]    stable0, stable1;
    logic [NUM_PORTS-1:0] chg;
    logic [NUM_PORTS-1:0] chg_flag_q, chg_flag_d;
    logic [NUM_PORTS-1:0] irq_mask_q, irq_mask_d;
    logic [5:0]           reg_sel;
    logic                 unused_bits;

    io_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_deb0 (
        .io_clk   (io_clk),
        .reset    (reset),
        .pin_i    (in_port0),
        .stable_o (stable0),
        .chg_o    (chg[0])
    );

    io_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_deb1 (
        .io_clk   (io_clk),
        .reset    (reset),
        .pin_i    (in_port1),
        .stable_o (stable1),
        .chg_o    (chg[1])
    );

    assign reg_sel     = addr[7:2];
    assign unused_bits = ^{addr[31:8], addr[1:0], wr_data[31:NUM_PORTS]};

    // Set is applied after clear so an event landing on the read-clear edge survives.
    always_comb begin
        chg_flag_d = chg_flag_q;
        if (rd_en && (reg_sel == IO_STAT)) begin
            chg_flag_d = '0;
        end
        chg_flag_d = chg_flag_d | chg;
    end

    always_comb begin
        irq_mask_d = irq_mask_q;
        if (wr_en && (reg_sel == IO_MASK)) begin
            irq_mask_d = wr_data[NUM_PORTS-1:0];
        end
    end

    always_ff @(posedge io_clk or posedge reset) begin
        if (reset) begin
            chg_flag_q <= '0;
            irq_mask_q <= '0;
        end else begin
            chg_flag_q <= chg_flag_d;
            irq_mask_q <= irq_mask_d;
        end
    end

    always_comb begin
        io_read_data = '0;
        case (reg_sel)
            IO_IN0:  io_read_data = zext_port(stable0);
            IO_IN1:  io_read_data = zext_port(stable1);
            IO_STAT: io_read_data = zext_flags(chg_flag_q);
            IO_MASK: io_read_data = zext_flags(irq_mask_q);
            default: io_read_data = '0;
        endcase
    end

    assign irq = |(chg_flag_q & irq_mask_q);

endmodule

// File: tb/tb_io_input_ctrl.sv
// Scoreboard bench for io_input_ctrl: stimulus queues expected values,
// a monitor pops and compares whenever a read or irq sample is presented.
module tb_io_input_ctrl;

    logic        io_clk;
    logic        reset;
    logic [3:0]  in_port0, in_port1;
    logic [31:0] addr;
    logic        rd_en, wr_en;
    logic [31:0] wr_data;
    logic [31:0] io_read_data;
    logic        irq;

    io_input_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (3)
    ) dut (
        .io_clk       (io_clk),
        .reset        (reset),
        .in_port0     (in_port0),
        .in_port1     (in_port1),
        .addr         (addr),
        .rd_en        (rd_en),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .io_read_data (io_read_data),
        .irq          (irq)
    );

    initial begin
        io_clk = 1'b0;
        forever #5 io_clk = ~io_clk;
    end

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] rd_q[$];
    string       rd_n[$];
    logic        irq_q[$];
    string       irq_n[$];
    logic        chk_rd    = 1'b0;
    logic        chk_irq   = 1'b0;
    logic        probe     = 1'b0;
    logic        final_chk = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    endtask

    // Monitor: samples on the falling edge, or on an async probe while reset is applied.
    always @(negedge io_clk or posedge probe) begin
        logic [31:0] e;
        logic        ei;
        string       nm;
        if (chk_rd) begin
            if (rd_q.size() == 0) begin
                n_checks++;
                $display("FAIL rd_queue: got empty queue, expected an entry");
            end else begin
                e  = rd_q.pop_front();
                nm = rd_n.pop_front();
                check(nm, io_read_data, e);
            end
        end
        if (chk_irq) begin
            if (irq_q.size() == 0) begin
                n_checks++;
                $display("FAIL irq_queue: got empty queue, expected an entry");
            end else begin
                ei = irq_q.pop_front();
                nm = irq_n.pop_front();
                check(nm, {31'b0, irq}, {31'b0, ei});
            end
        end
        if (final_chk) begin
            check("rd_queue_drained", 32'(rd_q.size()), 32'd0);
            check("irq_queue_drained", 32'(irq_q.size()), 32'd0);
        end
    end

    task automatic tick();
        @(posedge io_clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] e, input string nm);
        addr   = a;
        rd_en  = 1'b1;
        chk_rd = 1'b1;
        rd_q.push_back(e);
        rd_n.push_back(nm);
        tick();
        rd_en  = 1'b0;
        chk_rd = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr    = a;
        wr_data = d;
        wr_en   = 1'b1;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic rdwr(input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] e, input string nm);
        wr_data = d;
        wr_en   = 1'b1;
        rd(a, e, nm);
        wr_en   = 1'b0;
    endtask

    task automatic peek_irq(input logic e, input string nm);
        chk_irq = 1'b1;
        irq_q.push_back(e);
        irq_n.push_back(nm);
        tick();
        chk_irq = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish by 100us, expected finish");
        $fatal(1);
    end

    initial begin
        reset    = 1'b1;
        in_port0 = 4'h0;
        in_port1 = 4'h0;
        addr     = 32'h0;
        rd_en    = 1'b0;
        wr_en    = 1'b0;
        wr_data  = 32'h0;
        ticks(3);
        reset = 1'b0;

        // Reset state
        rd(32'h80, 32'h0, "rst_in0");
        rd(32'h84, 32'h0, "rst_in1");
        rd(32'h88, 32'h0, "rst_stat");
        rd(32'h8C, 32'h0, "rst_mask");
        rd(32'h90, 32'h0, "unmapped");
        peek_irq(1'b0, "rst_irq");

        // Debounce latency: pin set before edge 1, accepted at edge 7
        in_port0 = 4'h5;
        ticks(6);
        rd(32'h80, 32'h0, "in0_edge6");
        rd(32'h80, 32'h5, "in0_edge7");
        rd(32'h84, 32'h0, "in1_untouched");
        rd(32'h88, 32'h1, "stat_chg0");
        rd(32'h88, 32'h0, "stat_cleared");

        // Glitch shorter than the debounce window
        in_port1 = 4'hA;
        ticks(3);
        in_port1 = 4'h0;
        for (int i = 0; i < 10; i++) begin
            rd(32'h84, 32'h0, "glitch_in1");
            rd(32'h88, 32'h0, "glitch_stat");
        end

        // Mask write and interrupt
        wr(32'h80, 32'hF);
        rd(32'h80, 32'h5, "ro_write_ignored");
        wr(32'h8C, 32'hFFFF_FFFD);
        rd(32'h8C, 32'h1, "mask_low_bits");
        peek_irq(1'b0, "irq_idle");
        in_port0 = 4'h9;
        ticks(6);
        peek_irq(1'b0, "irq_edge6");
        peek_irq(1'b1, "irq_edge7");
        rd(32'h80, 32'h9, "in0_new");
        rd(32'h88, 32'h1, "stat_irq_src");
        peek_irq(1'b0, "irq_after_clear");
        rd(32'h88, 32'h0, "stat_after_clear");

        // Port1 change lands on the read-clear edge
        in_port0 = 4'hC;
        ticks(2);
        in_port1 = 4'h3;
        ticks(6);
        rd(32'h88, 32'h1, "stat_old_flags");
        peek_irq(1'b0, "irq_p1_masked_out");
        rd(32'h88, 32'h2, "stat_set_wins");
        rd(32'h88, 32'h0, "stat_final_clear");
        rd(32'h84, 32'h3, "in1_new");

        // Simultaneous load and store to the mask register
        rdwr(32'h8C, 32'h3, 32'h1, "mask_rdwr_old");
        rd(32'h8C, 32'h3, "mask_rdwr_new");

        // Reset mid-operation with irq high and port0 counter at 2
        in_port1 = 4'h7;
        ticks(6);
        peek_irq(1'b0, "irq_before_p1");
        peek_irq(1'b1, "irq_p1");
        in_port0 = 4'h3;
        ticks(5);
        reset = 1'b1;
        #1;
        addr    = 32'h80;
        chk_rd  = 1'b1;
        chk_irq = 1'b1;
        rd_q.push_back(32'h0);
        rd_n.push_back("rst_async_in0");
        irq_q.push_back(1'b0);
        irq_n.push_back("rst_async_irq");
        #1 probe = 1'b1;
        #1 probe = 1'b0;
        chk_rd  = 1'b0;
        chk_irq = 1'b0;
        rd(32'h84, 32'h0, "rst_hold_in1");
        rd(32'h88, 32'h0, "rst_hold_stat");
        rd(32'h8C, 32'h0, "rst_hold_mask");
        reset = 1'b0;
        ticks(6);
        rd(32'h80, 32'h0, "rel_in0_edge6");
        rd(32'h80, 32'h3, "rel_in0_edge7");
        rd(32'h84, 32'h7, "rel_in1");
        rd(32'h88, 32'h3, "rel_stat");
        peek_irq(1'b0, "rel_irq_mask_cleared");

        ticks(2);
        final_chk = 1'b1;
        @(negedge io_clk);
        #1;
        final_chk = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
